// File: rtl/div_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
//   Shared types and helpers for the sequential restoring divider.
//   - div_state_t : divider sequencer states (IDLE, ITER, DONE)
//   - cnt_w()     : width of the iteration counter for an N-bit divide
// ---------------------------------------------------------------------------
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Counter holds N-1 down to 0, so $clog2(N) bits suffice (N >= 2).
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/div_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// div_seq_ctrl_if
//   Start/busy/done handshake bundle between the issuing logic (master)
//   and the divide sequencer (slave).
//   start       : request, master -> slave
//   dividend    : N-bit unsigned operand, master -> slave
//   divisor     : N-bit unsigned operand, master -> slave
//   busy        : iteration in progress, slave -> master
//   done        : one-cycle completion pulse, slave -> master
//   quotient    : N-bit result, slave -> master
//   remainder   : N-bit result, slave -> master
//   div_by_zero : status of the last completed op, slave -> master
// ---------------------------------------------------------------------------
interface div_seq_ctrl_if #(
    parameter int N = 4
);
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_seq_ctrl_resta.sv
// ---------------------------------------------------------------------------
// resta
//   W-bit two's-complement subtractor.
//   A_num  : minuend (W bits)
//   B_num  : subtrahend (W bits)
//   result : A_num - B_num (W bits, wraps)
//   sign   : MSB of result (borrow when operands are sized so that the
//            true difference fits in W bits signed)
// ---------------------------------------------------------------------------
module resta #(
    parameter int W = 5
) (
    input  logic [W-1:0] A_num,
    input  logic [W-1:0] B_num,
    output logic [W-1:0] result,
    output logic         sign
);
    assign result = A_num - B_num;
    assign sign   = result[W-1];
endmodule

// File: rtl/div_seq_ctrl.sv
// ---------------------------------------------------------------------------
// div_seq_ctrl
//   Iterative unsigned restoring divider sequencer: one trial subtraction
//   and one quotient bit per cycle through a single shared subtractor.
//   clk : clock, all state on the rising edge
//   rst : synchronous active-high reset
//   bus : div_seq_ctrl_if.slave handshake (start/operands in,
//         busy/done/quotient/remainder/div_by_zero out)
// ---------------------------------------------------------------------------
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    div_seq_ctrl_if.slave bus
);
    localparam int CNT_W = cnt_w(N);

    div_state_t         r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt,   w_cnt_nxt;
    logic [N-1:0]       r_r,     w_r_nxt;     // partial remainder
    logic [N-1:0]       r_q,     w_q_nxt;     // dividend shifting out / quotient shifting in
    logic [N-1:0]       r_d,     w_d_nxt;     // captured divisor
    logic [N-1:0]       r_quot,  w_quot_nxt;
    logic [N-1:0]       r_rem,   w_rem_nxt;
    logic               r_dbz,   w_dbz_nxt;

    logic [N:0]         w_s;
    logic [N:0]         w_t;
    logic               w_borrow;
    logic [N-1:0]       w_r_step;
    logic [N-1:0]       w_q_step;

    // Shift the next dividend bit into the partial remainder and trial-subtract.
    // R < D holds each step, so S - D fits in N+1 signed bits and the
    // subtractor MSB is a true borrow.
    assign w_s = {r_r, r_q[N-1]};

    resta #(.W(N + 1)) u_sub (
        .A_num  (w_s),
        .B_num  ({1'b0, r_d}),
        .result (w_t),
        .sign   (w_borrow)
    );

    assign w_r_step = w_borrow ? w_s[N-1:0] : w_t[N-1:0];
    assign w_q_step = {r_q[N-2:0], ~w_borrow};

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_r_nxt     = r_r;
        w_q_nxt     = r_q;
        w_d_nxt     = r_d;
        w_quot_nxt  = r_quot;
        w_rem_nxt   = r_rem;
        w_dbz_nxt   = r_dbz;

        case (r_state)
            IDLE, DONE: begin
                if (bus.start) begin
                    if (bus.divisor != '0) begin
                        w_state_nxt = ITER;
                        w_r_nxt     = '0;
                        w_q_nxt     = bus.dividend;
                        w_d_nxt     = bus.divisor;
                        w_cnt_nxt   = CNT_W'(N - 1);
                    end else begin
                        w_state_nxt = DONE;
                        w_quot_nxt  = '1;
                        w_rem_nxt   = bus.dividend;
                        w_dbz_nxt   = 1'b1;
                    end
                end else if (r_state == DONE) begin
                    w_state_nxt = IDLE;
                end
            end
            ITER: begin
                w_r_nxt = w_r_step;
                w_q_nxt = w_q_step;
                if (r_cnt == '0) begin
                    w_state_nxt = DONE;
                    w_quot_nxt  = w_q_step;
                    w_rem_nxt   = w_r_step;
                    w_dbz_nxt   = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_r     <= '0;
            r_q     <= '0;
            r_d     <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dbz   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_r     <= w_r_nxt;
            r_q     <= w_q_nxt;
            r_d     <= w_d_nxt;
            r_quot  <= w_quot_nxt;
            r_rem   <= w_rem_nxt;
            r_dbz   <= w_dbz_nxt;
        end
    end

    assign bus.busy        = (r_state == ITER);
    assign bus.done        = (r_state == DONE);
    assign bus.quotient    = r_quot;
    assign bus.remainder   = r_rem;
    assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_div_seq_ctrl
//   Directed and random checks of div_seq_ctrl at N=4 and N=8.
// ---------------------------------------------------------------------------
module tb_div_seq_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    div_seq_ctrl_if #(.N(4)) bus4 ();
    div_seq_ctrl_if #(.N(8)) bus8 ();

    div_seq_ctrl #(.N(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
    div_seq_ctrl #(.N(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Full N=4 operation from IDLE, checking latency, busy window and results.
    task automatic div4(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] eq, input logic [3:0] er, input logic ez);
        bus4.start    = 1'b1;
        bus4.dividend = a;
        bus4.divisor  = b;
        @(negedge clk);
        bus4.start = 1'b0;
        if (b != 4'd0) begin
            for (int k = 0; k < 4; k++) begin
                check("busy4", bus4.busy, 1);
                check("done4_early", bus4.done, 0);
                @(negedge clk);
            end
        end
        check("busy4_off", bus4.busy, 0);
        check("done4", bus4.done, 1);
        check("quot4", bus4.quotient, eq);
        check("rem4", bus4.remainder, er);
        check("dbz4", bus4.div_by_zero, ez);
        @(negedge clk);
        check("done4_pulse", bus4.done, 0);
        check("quot4_hold", bus4.quotient, eq);
        check("rem4_hold", bus4.remainder, er);
    endtask

    task automatic div8(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] eq, er;
        int  cyc, nbusy;
        bit  seen;
        eq = (b == 8'd0) ? 8'hFF : a / b;
        er = (b == 8'd0) ? a : a % b;
        bus8.start    = 1'b1;
        bus8.dividend = a;
        bus8.divisor  = b;
        @(negedge clk);
        bus8.start = 1'b0;
        cyc = 0; nbusy = 0; seen = 1'b0;
        while (!seen && cyc < 20) begin
            if (bus8.done) seen = 1'b1;
            else begin
                if (bus8.busy) nbusy++;
                @(negedge clk);
                cyc++;
            end
        end
        check("d8_timeout", seen, 1);
        check("d8_busy_cycles", nbusy, (b == 8'd0) ? 0 : 8);
        check("d8_quot", bus8.quotient, eq);
        check("d8_rem", bus8.remainder, er);
        check("d8_dbz", bus8.div_by_zero, b == 8'd0);
        @(negedge clk);
    endtask

    initial begin
        int ndone;
        logic [3:0] cq, cr, ra, rb;

        rst = 1'b1;
        bus4.start = 1'b0; bus4.dividend = '0; bus4.divisor = '0;
        bus8.start = 1'b0; bus8.dividend = '0; bus8.divisor = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", bus4.busy, 0);
        check("rst_done", bus4.done, 0);
        check("rst_quot", bus4.quotient, 0);
        check("rst_rem", bus4.remainder, 0);
        check("rst_dbz", bus4.div_by_zero, 0);
        rst = 1'b0;
        @(negedge clk);

        div4(4'd13, 4'd4, 4'd3,  4'd1, 1'b0);
        div4(4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
        div4(4'd3,  4'd9, 4'd0,  4'd3, 1'b0);
        div4(4'd0,  4'd5, 4'd0,  4'd0, 1'b0);
        div4(4'd7,  4'd0, 4'hF,  4'd7, 1'b1);

        // start during ITER is ignored
        bus4.start = 1'b1; bus4.dividend = 4'd13; bus4.divisor = 4'd4;
        @(negedge clk);
        bus4.start = 1'b0;
        @(negedge clk);
        bus4.start = 1'b1; bus4.dividend = 4'd9; bus4.divisor = 4'd2;
        @(negedge clk);
        bus4.start = 1'b0;
        ndone = 0; cq = '0; cr = '0;
        for (int k = 0; k < 8; k++) begin
            if (bus4.done) begin
                ndone++;
                if (ndone == 1) begin cq = bus4.quotient; cr = bus4.remainder; end
            end
            @(negedge clk);
        end
        check("ign_done_count", ndone, 1);
        check("ign_quot", cq, 3);
        check("ign_rem", cr, 1);

        // back-to-back: 14/3 issued in the DONE cycle of 13/4, then 7/0 in the DONE of 14/3
        bus4.start = 1'b1; bus4.dividend = 4'd13; bus4.divisor = 4'd4;
        @(negedge clk);
        bus4.start = 1'b0;
        repeat (4) @(negedge clk);
        check("b2b_done1", bus4.done, 1);
        check("b2b_quot1", bus4.quotient, 3);
        bus4.start = 1'b1; bus4.dividend = 4'd14; bus4.divisor = 4'd3;
        @(negedge clk);
        bus4.start = 1'b0;
        check("b2b_no_done", bus4.done, 0);
        for (int k = 0; k < 4; k++) begin
            check("b2b_busy", bus4.busy, 1);
            check("b2b_quot_hold", bus4.quotient, 3);
            check("b2b_rem_hold", bus4.remainder, 1);
            @(negedge clk);
        end
        check("b2b_done2", bus4.done, 1);
        check("b2b_quot2", bus4.quotient, 4);
        check("b2b_rem2", bus4.remainder, 2);
        bus4.start = 1'b1; bus4.dividend = 4'd7; bus4.divisor = 4'd0;
        @(negedge clk);
        bus4.start = 1'b0;
        check("b2b_dz_done", bus4.done, 1);
        check("b2b_dz_busy", bus4.busy, 0);
        check("b2b_dz_quot", bus4.quotient, 4'hF);
        check("b2b_dz_rem", bus4.remainder, 7);
        check("b2b_dz_flag", bus4.div_by_zero, 1);
        @(negedge clk);
        check("b2b_dz_pulse", bus4.done, 0);

        // reset in the third ITER cycle aborts
        bus4.start = 1'b1; bus4.dividend = 4'd13; bus4.divisor = 4'd4;
        @(negedge clk);
        bus4.start = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_busy_pre", bus4.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", bus4.busy, 0);
        check("abort_done", bus4.done, 0);
        check("abort_quot", bus4.quotient, 0);
        check("abort_rem", bus4.remainder, 0);
        check("abort_dbz", bus4.div_by_zero, 0);
        ndone = 0;
        for (int k = 0; k < 6; k++) begin
            if (bus4.done || bus4.busy) ndone++;
            @(negedge clk);
        end
        check("abort_quiet", ndone, 0);
        div4(4'd13, 4'd4, 4'd3, 4'd1, 1'b0);

        // N=4 random sweep
        for (int k = 0; k < 20; k++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            div4(ra, rb, (rb == 4'd0) ? 4'hF : ra / rb,
                 (rb == 4'd0) ? ra : ra % rb, rb == 4'd0);
        end

        // N=8 edges and random sweep
        div8(8'd255, 8'd1);
        div8(8'd255, 8'd255);
        div8(8'd1,   8'd255);
        div8(8'd128, 8'd0);
        div8(8'd200, 8'd7);
        for (int k = 0; k < 40; k++)
            div8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
